// File: rtl/alu_seq_driver.sv
// alu_seq_driver: multi-byte sequencer driving an 8-bit combinational ALU.
// Splits one wide request (op, A, B, carry-in) into one ALU command per cycle,
// chains carry between byte slices and folds compare flags into one result.
// Optional build macro: ALU_SEQ_ILLEGAL_OP_EN adds the rsp_illegal output.
`timescale 1ns/1ps

module alu_seq_driver #(
   parameter int unsigned NBYTES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_op,
   input  logic [8*NBYTES-1:0]   req_a,
   input  logic [8*NBYTES-1:0]   req_b,
   input  logic                  req_cin,
   output logic [3:0]            alu_cmd,
   output logic [7:0]            alu_inA,
   output logic [7:0]            alu_inB,
   output logic                  alu_shiftcarry_in,
   input  logic [7:0]            alu_rslt,
   input  logic                  alu_shiftcarry_out,
   input  logic                  alu_branchFlag,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [8*NBYTES-1:0]   rsp_result,
   output logic                  rsp_carry,
`ifdef ALU_SEQ_ILLEGAL_OP_EN
   output logic                  rsp_illegal,
`endif
   output logic                  rsp_flag
);

   localparam int unsigned W = 8 * NBYTES;
   localparam logic [1:0] LastIdx = 2'(NBYTES - 1);

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpXor  = 4'b0001;
   localparam logic [3:0] OpOr   = 4'b0010;
   localparam logic [3:0] OpLsl  = 4'b0011;
   localparam logic [3:0] OpLsr  = 4'b0100;
   localparam logic [3:0] OpAdd  = 4'b0101;
   localparam logic [3:0] OpSub  = 4'b0110;
   localparam logic [3:0] OpPass = 4'b0111;
   localparam logic [3:0] OpLt   = 4'b1000;
   localparam logic [3:0] OpGt   = 4'b1001;
   localparam logic [3:0] OpEq   = 4'b1010;

   typedef enum logic [1:0] {StIdle, StRun, StCmpDecide, StResp} state_e;

   state_e         state_q, state_d;
   logic [3:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [1:0]     idx_q, idx_d;
   logic [W-1:0]   res_q, res_d;
   logic           carry_q, carry_d;
   logic           flag_q, flag_d;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
   logic           ill_q, ill_d;
`endif

   logic           is_cmp;
   logic           is_ill;
   logic           last;
   logic [1:0]     pos;
   logic [7:0]     a_byte;
   logic [7:0]     b_byte;

   // Op classification and the byte slice addressed this cycle
   always_comb begin
      is_cmp = (op_q == OpLt) || (op_q == OpGt) || (op_q == OpEq);
      is_ill = (op_q > OpEq);
      last   = (idx_q == LastIdx);
      // LSR and compares walk from the top byte down
      pos    = ((op_q == OpLsr) || is_cmp) ? (LastIdx - idx_q) : idx_q;
      a_byte = a_q[8*pos +: 8];
      b_byte = b_q[8*pos +: 8];
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) state_d = StRun;
         end
         StRun: begin
            if (is_ill) begin
               state_d = StResp;
            end else if (is_cmp) begin
               if (!alu_branchFlag) begin
                  state_d = (op_q == OpEq) ? StResp : StCmpDecide;
               end else if (last) begin
                  state_d = StResp;
               end
            end else if (last) begin
               state_d = StResp;
            end
         end
         StCmpDecide: state_d = StResp;
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic: handshake and ALU drive
   always_comb begin
      req_ready         = (state_q == StIdle);
      rsp_valid         = (state_q == StResp);
      alu_cmd           = OpPass;
      alu_inA           = 8'h00;
      alu_inB           = 8'h00;
      alu_shiftcarry_in = 1'b0;
      unique case (state_q)
         StRun: begin
            case (op_q)
               OpAnd, OpXor, OpOr, OpPass: begin
                  alu_cmd = op_q;
                  alu_inA = a_byte;
                  alu_inB = b_byte;
               end
               OpAdd: begin
                  alu_cmd           = OpAdd;
                  alu_inA           = a_byte;
                  alu_inB           = b_byte;
                  alu_shiftcarry_in = carry_q;
               end
               OpSub: begin
                  // A - B computed as A + ~B + 1; carry_q starts at 1
                  alu_cmd           = OpAdd;
                  alu_inA           = a_byte;
                  alu_inB           = ~b_byte;
                  alu_shiftcarry_in = carry_q;
               end
               OpLsl, OpLsr: begin
                  alu_cmd           = op_q;
                  alu_inA           = a_byte;
                  alu_shiftcarry_in = carry_q;
               end
               OpLt, OpGt, OpEq: begin
                  alu_cmd = OpEq;
                  alu_inA = a_byte;
                  alu_inB = b_byte;
               end
               default: ;
            endcase
         end
         StCmpDecide: begin
            alu_cmd = op_q;
            alu_inA = a_byte;
            alu_inB = b_byte;
         end
         default: ;
      endcase
   end

   // Datapath next-state: request latch, byte capture, carry chain, flag fold
   always_comb begin
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      res_d   = res_q;
      carry_d = carry_q;
      flag_d  = flag_q;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      ill_d   = ill_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               op_d   = req_op;
               a_d    = req_a;
               b_d    = req_b;
               idx_d  = 2'd0;
               res_d  = '0;
               flag_d = 1'b0;
               case (req_op)
                  OpSub:               carry_d = 1'b1;
                  OpAdd, OpLsl, OpLsr: carry_d = req_cin;
                  default:             carry_d = 1'b0;
               endcase
`ifdef ALU_SEQ_ILLEGAL_OP_EN
               ill_d = (req_op > OpEq);
`endif
            end
         end
         StRun: begin
            case (op_q)
               OpAnd, OpXor, OpOr, OpPass: begin
                  res_d[8*pos +: 8] = alu_rslt;
               end
               OpAdd, OpSub, OpLsl, OpLsr: begin
                  res_d[8*pos +: 8] = alu_rslt;
                  carry_d           = alu_shiftcarry_out;
               end
               OpLt, OpGt, OpEq: begin
                  // All bytes equal: only EQ reports true
                  if (alu_branchFlag && last) flag_d = (op_q == OpEq);
               end
               default: ;
            endcase
            // Hold the index on an unequal byte so CMP_DECIDE revisits it
            if (!last && !(is_cmp && !alu_branchFlag)) idx_d = idx_q + 2'd1;
         end
         StCmpDecide: flag_d = alu_branchFlag;
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q    <= OpPass;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= 2'd0;
         res_q   <= '0;
         carry_q <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         flag_q  <= flag_d;
      end
   end

`ifdef ALU_SEQ_ILLEGAL_OP_EN
   // Illegal-opcode marker register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ill_q <= 1'b0;
      end else begin
         ill_q <= ill_d;
      end
   end

   assign rsp_illegal = ill_q;
`endif

   assign rsp_result = res_q;
   assign rsp_carry  = carry_q;
   assign rsp_flag   = flag_q;

endmodule

// File: tb/tb_alu_seq_driver.sv
// tb_alu_seq_driver: table-driven and scoreboard bench for alu_seq_driver (NBYTES=2)
// with a behavioural model of the 8-bit combinational ALU.
`timescale 1ns/1ps

module tb_alu_seq_driver;

   localparam int unsigned NB = 2;
   localparam int unsigned W  = 8 * NB;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_op;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic          req_cin;
   logic [3:0]    alu_cmd;
   logic [7:0]    alu_inA;
   logic [7:0]    alu_inB;
   logic          alu_shiftcarry_in;
   logic [7:0]    alu_rslt;
   logic          alu_shiftcarry_out;
   logic          alu_branchFlag;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_result;
   logic          rsp_carry;
   logic          rsp_flag;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
   logic          rsp_illegal;
`endif

   alu_seq_driver #(.NBYTES(NB)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_op             (req_op),
      .req_a              (req_a),
      .req_b              (req_b),
      .req_cin            (req_cin),
      .alu_cmd            (alu_cmd),
      .alu_inA            (alu_inA),
      .alu_inB            (alu_inB),
      .alu_shiftcarry_in  (alu_shiftcarry_in),
      .alu_rslt           (alu_rslt),
      .alu_shiftcarry_out (alu_shiftcarry_out),
      .alu_branchFlag     (alu_branchFlag),
      .rsp_valid          (rsp_valid),
      .rsp_ready          (rsp_ready),
      .rsp_result         (rsp_result),
      .rsp_carry          (rsp_carry),
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      .rsp_illegal        (rsp_illegal),
`endif
      .rsp_flag           (rsp_flag)
   );

   always #5 clk = ~clk;

   // Behavioural 8-bit ALU
   always_comb begin
      alu_rslt           = 8'h00;
      alu_shiftcarry_out = 1'b0;
      alu_branchFlag     = 1'b0;
      case (alu_cmd)
         4'b0000: alu_rslt = alu_inA & alu_inB;
         4'b0001: alu_rslt = alu_inA ^ alu_inB;
         4'b0010: alu_rslt = alu_inA | alu_inB;
         4'b0011: begin
            alu_rslt           = {alu_inA[6:0], alu_shiftcarry_in};
            alu_shiftcarry_out = alu_inA[7];
         end
         4'b0100: begin
            alu_rslt           = {alu_shiftcarry_in, alu_inA[7:1]};
            alu_shiftcarry_out = alu_inA[0];
         end
         4'b0101: {alu_shiftcarry_out, alu_rslt} =
                  {1'b0, alu_inA} + {1'b0, alu_inB} + {8'h00, alu_shiftcarry_in};
         4'b0110: alu_rslt = alu_inA - alu_inB;
         4'b0111: alu_rslt = alu_inA;
         4'b1000: alu_branchFlag = (alu_inA < alu_inB);
         4'b1001: alu_branchFlag = (alu_inA > alu_inB);
         4'b1010: alu_branchFlag = (alu_inA == alu_inB);
         default: ;
      endcase
   end

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] res;
      logic         carry;
      logic         flag;
      logic         ill;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         carry;
      logic         flag;
      logic         ill;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   vec_t vt[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference model of the wide operation, including accept-to-valid latency
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic cin);
      exp_t       e;
      logic [W:0] s;
      bit         found;
      int         i;
      e.res = '0; e.carry = 1'b0; e.flag = 1'b0; e.ill = 1'b0; e.lat = NB + 1;
      found = 1'b0; i = 0;
      case (op)
         4'h0: e.res = a & b;
         4'h1: e.res = a ^ b;
         4'h2: e.res = a | b;
         4'h3: begin e.res = {a[W-2:0], cin}; e.carry = a[W-1]; end
         4'h4: begin e.res = {cin, a[W-1:1]}; e.carry = a[0]; end
         4'h5: begin s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; e.res = s[W-1:0]; e.carry = s[W]; end
         4'h6: begin e.res = a - b; e.carry = (a >= b); end
         4'h7: e.res = a;
         4'h8, 4'h9, 4'hA: begin
            e.flag = (op == 4'h8) ? (a < b) : (op == 4'h9) ? (a > b) : (a == b);
            for (int k = NB - 1; k >= 0; k--) begin
               if (!found && (a[8*k +: 8] != b[8*k +: 8])) begin
                  found = 1'b1;
                  i = NB - 1 - k;
               end
            end
            if (found) e.lat = (op == 4'hA) ? i + 2 : i + 3;
         end
         default: begin e.ill = 1'b1; e.lat = 2; end
      endcase
      return e;
   endfunction

   task automatic apply_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      sb_q.delete();
   endtask

   // Drive a request, push its expectation, return at T+1 (#1 after the accept edge)
   task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input exp_t e, output bit ok);
      int wait_cyc = 0;
      req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
      while (!req_ready && wait_cyc < 20) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      ok = req_ready;
      if (!ok) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         apply_reset();
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      sb_q.push_back(e);
   endtask

   // Wait for the response, compare against the scoreboard head, optionally stall, consume
   task automatic finish_op(input string name, input int lat0, input int hold);
      int   lat = lat0;
      exp_t e;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
         apply_reset();
         return;
      end
      if (sb_q.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      check({name, "_result"}, 32'(rsp_result), 32'(e.res));
      check({name, "_carry"},  32'(rsp_carry),  32'(e.carry));
      check({name, "_flag"},   32'(rsp_flag),   32'(e.flag));
      check({name, "_lat"},    32'(lat),        32'(e.lat));
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      check({name, "_illegal"}, 32'(rsp_illegal), 32'(e.ill));
`endif
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({name, "_hold_valid"},  32'(rsp_valid),  32'd1);
         check({name, "_hold_result"}, 32'(rsp_result), 32'(e.res));
         check({name, "_hold_carry"},  32'(rsp_carry),  32'(e.carry));
         check({name, "_hold_ready"},  32'(req_ready),  32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({name, "_done_valid"}, 32'(rsp_valid), 32'd0);
      check({name, "_done_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      bit            ok;
      exp_t          e;
      logic [3:0]    rop;
      logic [W-1:0]  ra, rb;
      logic          rc;

      // op, a, b, cin, result, carry, flag, illegal, latency
      vt.push_back('{4'h5, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 3});
      vt.push_back('{4'h5, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3});
      vt.push_back('{4'h5, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 3});
      vt.push_back('{4'h6, 16'h1234, 16'h1235, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3});
      vt.push_back('{4'h6, 16'h1235, 16'h1234, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 3});
      vt.push_back('{4'h6, 16'h1235, 16'h1234, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 3});
      vt.push_back('{4'h3, 16'h8001, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 3});
      vt.push_back('{4'h4, 16'h8001, 16'h0000, 1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 3});
      vt.push_back('{4'h0, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 3});
      vt.push_back('{4'h1, 16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 3});
      vt.push_back('{4'h2, 16'hF0F0, 16'h0F00, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1'b0, 3});
      vt.push_back('{4'h7, 16'h1234, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 3});
      vt.push_back('{4'h8, 16'h1200, 16'h1201, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4});
      vt.push_back('{4'h8, 16'h1201, 16'h1200, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4});
      vt.push_back('{4'hA, 16'hAB00, 16'hAC00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2});
      vt.push_back('{4'hA, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3});
      vt.push_back('{4'h9, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3});
      vt.push_back('{4'h9, 16'h1300, 16'h12FF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3});
      vt.push_back('{4'hC, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 2});
      vt.push_back('{4'h5, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 3});

      reset_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_a = '0; req_b = '0;
      req_cin = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_result",    32'(rsp_result), 32'd0);
      check("rst_carry",     32'(rsp_carry), 32'd0);
      check("rst_flag",      32'(rsp_flag), 32'd0);
      check("idle_alu_cmd",  32'(alu_cmd), 32'h7);
      check("idle_alu_ab",   32'({alu_inA, alu_inB, 7'd0, alu_shiftcarry_in}), 32'd0);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      check("rst_illegal",   32'(rsp_illegal), 32'd0);
`endif
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven vectors
      foreach (vt[i]) begin
         e.res = vt[i].res; e.carry = vt[i].carry; e.flag = vt[i].flag;
         e.ill = vt[i].ill; e.lat = vt[i].lat;
         start_op(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, e, ok);
         if (ok) finish_op($sformatf("vec%0d", i), 1, 0);
      end

      // LSR walks byte 1 then byte 0, chaining the shift-out downward
      start_op(4'h4, 16'h8001, 16'h0000, 1'b0, model(4'h4, 16'h8001, 16'h0000, 1'b0), ok);
      if (ok) begin
         check("lsr_c1_cmd", 32'(alu_cmd), 32'h4);
         check("lsr_c1_inA", 32'(alu_inA), 32'h80);
         @(posedge clk); #1;
         check("lsr_c2_inA", 32'(alu_inA), 32'h01);
         check("lsr_c2_cin", 32'(alu_shiftcarry_in), 32'd0);
         finish_op("lsr_seq", 2, 0);
      end

      // SUB issues ADD with inverted B and forced carry-in regardless of req_cin
      start_op(4'h6, 16'h1235, 16'h1234, 1'b0, model(4'h6, 16'h1235, 16'h1234, 1'b0), ok);
      if (ok) begin
         check("sub_c1_cmd", 32'(alu_cmd), 32'h5);
         check("sub_c1_ops", 32'({alu_inA, alu_inB, 7'd0, alu_shiftcarry_in}), 32'h35CB01);
         @(posedge clk); #1;
         check("sub_c2_ops", 32'({alu_inA, alu_inB, 7'd0, alu_shiftcarry_in}), 32'h12ED01);
         finish_op("sub_seq", 2, 0);
      end

      // LT: two EQ cycles, then LT on the unequal low byte
      start_op(4'h8, 16'h1200, 16'h1201, 1'b0, model(4'h8, 16'h1200, 16'h1201, 1'b0), ok);
      if (ok) begin
         check("lt_c1_cmd", 32'({alu_cmd, alu_inA}), 32'hA12);
         @(posedge clk); #1;
         check("lt_c2_cmd", 32'({alu_cmd, alu_inA, alu_inB}), 32'hA0001);
         @(posedge clk); #1;
         check("lt_c3_cmd", 32'({alu_cmd, alu_inA, alu_inB}), 32'h80001);
         finish_op("lt_seq", 3, 0);
      end

      // Backpressure: response held five cycles
      start_op(4'h5, 16'h1234, 16'h1111, 1'b0, model(4'h5, 16'h1234, 16'h1111, 1'b0), ok);
      if (ok) finish_op("bp", 1, 5);

      // Asynchronous reset during RUN discards the operation
      start_op(4'h5, 16'h4321, 16'h0101, 1'b0, model(4'h5, 16'h4321, 16'h0101, 1'b0), ok);
      if (ok) begin
         #1 reset_n = 1'b0;
         #1;
         check("arst_valid",  32'(rsp_valid), 32'd0);
         check("arst_ready",  32'(req_ready), 32'd1);
         check("arst_result", 32'(rsp_result), 32'd0);
         check("arst_alu",    32'(alu_cmd), 32'h7);
         #2 reset_n = 1'b1;
         sb_q.delete();
         for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("arst_no_rsp", 32'({rsp_valid, req_ready}), 32'b01);
         end
      end

      // Scoreboard-checked random traffic
      for (int r = 0; r < 24; r++) begin
         rop = 4'($urandom_range(0, 11));
         ra  = W'($urandom);
         rb  = ($urandom_range(0, 2) == 0) ? ra : W'($urandom);
         if ($urandom_range(0, 1) == 1) rb[W-1:W-8] = ra[W-1:W-8];
         rc  = 1'($urandom_range(0, 1));
         start_op(rop, ra, rb, rc, model(rop, ra, rb, rc), ok);
         if (ok) finish_op($sformatf("rnd%0d_op%0h", r, rop), 1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
